// File: rtl/rs_multi_pkg.sv
// Shared defaults for the reservation station slice.
package rs_multi_pkg;
  localparam int unsigned RS_DEPTH  = 16;
  localparam int unsigned RS_N_CDB  = 2;
  localparam int unsigned RS_NICK_W = 4;
  localparam int unsigned RS_DATA_W = 32;
  localparam int unsigned RS_ADDR_W = 32;
  localparam int unsigned RS_IMM_W  = 32;
  localparam int unsigned RS_OP_W   = 6;
  // Nick value meaning "operand already valid"; never broadcast on a CDB.
  localparam int unsigned NICK_NONE = 0;
endpackage

// File: rtl/rs_age_sel.sv
// Age matrix tracking allocation order, plus oldest-ready one-hot select.
module rs_age_sel
  import rs_multi_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] issue_oh,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);
  // age_q[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic [DEPTH-1:0]            blocked;

  always_comb begin
    age_d = age_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (issue_oh[i]) age_d[i] = '0;
    end
    // Stale bits in columns of free entries are harmless: only ready (occupied) rows are consulted.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (alloc_oh[k]) begin
        age_d[k] = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (j != k && !issue_oh[j]) age_d[j][k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
      grant[i] = ready[i] & ~blocked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     age_q <= '0;
    else if (en) age_q <= age_d;
  end
endmodule

// File: rtl/rs_multi.sv
// Reservation station: multi-CDB wakeup, dispatch bypass, oldest-ready issue to EX.
module rs_multi
  import rs_multi_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH,
  parameter int unsigned N_CDB  = RS_N_CDB,
  parameter int unsigned NICK_W = RS_NICK_W,
  parameter int unsigned DATA_W = RS_DATA_W,
  parameter int unsigned ADDR_W = RS_ADDR_W,
  parameter int unsigned IMM_W  = RS_IMM_W,
  parameter int unsigned OP_W   = RS_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clr,
  input  logic                     iDP_en,
  input  logic [OP_W-1:0]          iDP_op,
  input  logic [ADDR_W-1:0]        iDP_pc,
  input  logic [IMM_W-1:0]         iDP_imm,
  input  logic [NICK_W-1:0]        iDP_rd_nick,
  input  logic [NICK_W-1:0]        iDP_rs1_nick,
  input  logic [NICK_W-1:0]        iDP_rs2_nick,
  input  logic [DATA_W-1:0]        iDP_rs1_dt,
  input  logic [DATA_W-1:0]        iDP_rs2_dt,
  input  logic [N_CDB-1:0]         iCDB_en,
  input  logic [N_CDB*NICK_W-1:0]  iCDB_nick,
  input  logic [N_CDB*DATA_W-1:0]  iCDB_dt,
  input  logic                     iEX_rdy,
  output logic                     oINF_full,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oEX_en,
  output logic [OP_W-1:0]          oEX_op,
  output logic [ADDR_W-1:0]        oEX_pc,
  output logic [IMM_W-1:0]         oEX_imm,
  output logic [NICK_W-1:0]        oEX_rd_nick,
  output logic [DATA_W-1:0]        oEX_rs1_dt,
  output logic [DATA_W-1:0]        oEX_rs2_dt
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              v;
    logic [NICK_W-1:0] n;
    logic [DATA_W-1:0] d;
  } opnd_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [NICK_W-1:0] rd;
    opnd_t             s1;
    opnd_t             s2;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [NICK_W-1:0] rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } issue_t;

  logic [DEPTH-1:0] occ_q, occ_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             ex_en_q, ex_en_d;
  issue_t           ex_q, ex_d;

  logic [DEPTH-1:0] ready, grant, alloc_oh, issue_oh;
  logic             alloc, issue;
  logic [IDX_W-1:0] free_idx, issue_idx;
  opnd_t            dp_s1, dp_s2;

  // Lowest enabled matching channel wins; nick 0 at dispatch means data is already valid.
  function automatic opnd_t resolve(input opnd_t o);
    resolve = o;
    if (!o.v) begin
      if (o.n == NICK_W'(NICK_NONE)) begin
        resolve.v = 1'b1;
      end else begin
        for (int unsigned c = N_CDB; c > 0; c--) begin
          if (iCDB_en[c-1] && iCDB_nick[(c-1)*NICK_W +: NICK_W] == o.n) begin
            resolve.v = 1'b1;
            resolve.d = iCDB_dt[(c-1)*DATA_W +: DATA_W];
          end
        end
      end
    end
  endfunction

  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!occ_q[i-1]) free_idx = IDX_W'(i-1);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = occ_q[i] & ent_q[i].s1.v & ent_q[i].s2.v;
      if (grant[i]) issue_idx = IDX_W'(i);
    end
    alloc    = iDP_en & ~(&occ_q);
    alloc_oh = alloc ? (DEPTH'(1) << free_idx) : '0;
    issue    = iEX_rdy & (|ready);
    issue_oh = issue ? grant : '0;
  end

  rs_age_sel #(.DEPTH(DEPTH)) u_age_sel (
    .clk      (clk),
    .rst      (rst | clr),
    .en       (rdy),
    .alloc_oh (alloc_oh),
    .issue_oh (issue_oh),
    .ready    (ready),
    .grant    (grant)
  );

  always_comb begin
    occ_d   = occ_q;
    ent_d   = ent_q;
    ex_en_d = 1'b0;
    ex_d    = ex_q;
    dp_s1   = resolve({1'b0, iDP_rs1_nick, iDP_rs1_dt});
    dp_s2   = resolve({1'b0, iDP_rs2_nick, iDP_rs2_dt});
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (issue_oh[i]) begin
        occ_d[i] = 1'b0;
      end else if (occ_q[i]) begin
        ent_d[i].s1 = resolve(ent_q[i].s1);
        ent_d[i].s2 = resolve(ent_q[i].s2);
      end
    end
    // free_idx was free at cycle start, so it never collides with the issuing slot.
    if (alloc) begin
      occ_d[free_idx]     = 1'b1;
      ent_d[free_idx].op  = iDP_op;
      ent_d[free_idx].pc  = iDP_pc;
      ent_d[free_idx].imm = iDP_imm;
      ent_d[free_idx].rd  = iDP_rd_nick;
      ent_d[free_idx].s1  = dp_s1;
      ent_d[free_idx].s2  = dp_s2;
    end
    if (issue) begin
      ex_en_d = 1'b1;
      ex_d.op  = ent_q[issue_idx].op;
      ex_d.pc  = ent_q[issue_idx].pc;
      ex_d.imm = ent_q[issue_idx].imm;
      ex_d.rd  = ent_q[issue_idx].rd;
      ex_d.d1  = ent_q[issue_idx].s1.d;
      ex_d.d2  = ent_q[issue_idx].s2.d;
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(issue);
    full_d  = (count_d >= CNT_W'(DEPTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      occ_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ex_en_q <= 1'b0;
      ex_q    <= '0;
    end else if (rdy) begin
      occ_q   <= occ_d;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
      full_q  <= full_d;
      ex_en_q <= ex_en_d;
      ex_q    <= ex_d;
    end
  end

  assign oINF_full   = full_q;
  assign oCount      = count_q;
  assign oEX_en      = ex_en_q;
  assign oEX_op      = ex_q.op;
  assign oEX_pc      = ex_q.pc;
  assign oEX_imm     = ex_q.imm;
  assign oEX_rd_nick = ex_q.rd;
  assign oEX_rs1_dt  = ex_q.d1;
  assign oEX_rs2_dt  = ex_q.d2;
endmodule

// File: tb/tb_rs_multi.sv
// Directed plus random stimulus against an age-ordered queue model of the station.
module tb_rs_multi;
  localparam int DEPTH = 16;
  localparam int N_CDB = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        dp_en;
  logic [5:0]  dp_op;
  logic [31:0] dp_pc, dp_imm, dp_d1, dp_d2;
  logic [3:0]  dp_rd, dp_n1, dp_n2;
  logic [1:0]  cdb_en;
  logic [7:0]  cdb_nick;
  logic [63:0] cdb_dt;
  logic        ex_rdy;
  logic        o_full, o_en;
  logic [4:0]  o_count;
  logic [5:0]  o_op;
  logic [31:0] o_pc, o_imm, o_d1, o_d2;
  logic [3:0]  o_rd;

  rs_multi #(.DEPTH(DEPTH), .N_CDB(N_CDB), .NICK_W(4), .DATA_W(32),
             .ADDR_W(32), .IMM_W(32), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iDP_en(dp_en), .iDP_op(dp_op), .iDP_pc(dp_pc), .iDP_imm(dp_imm),
    .iDP_rd_nick(dp_rd), .iDP_rs1_nick(dp_n1), .iDP_rs2_nick(dp_n2),
    .iDP_rs1_dt(dp_d1), .iDP_rs2_dt(dp_d2),
    .iCDB_en(cdb_en), .iCDB_nick(cdb_nick), .iCDB_dt(cdb_dt),
    .iEX_rdy(ex_rdy), .oINF_full(o_full), .oCount(o_count),
    .oEX_en(o_en), .oEX_op(o_op), .oEX_pc(o_pc), .oEX_imm(o_imm),
    .oEX_rd_nick(o_rd), .oEX_rs1_dt(o_d1), .oEX_rs2_dt(o_d2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc, imm;
    logic [3:0]  rd;
    bit          v1, v2;
    logic [3:0]  n1, n2;
    logic [31:0] d1, d2;
  } ment_t;

  ment_t       rsq[$];
  logic        exp_en;
  logic [5:0]  exp_op;
  logic [31:0] exp_pc, exp_imm, exp_d1, exp_d2;
  logic [3:0]  exp_rd;
  int          checks = 0;
  int          errors = 0;

  function automatic bit cdb_hit(input logic [3:0] n, output logic [31:0] d);
    for (int c = 0; c < N_CDB; c++) begin
      if (cdb_en[c] && cdb_nick[c*4 +: 4] == n) begin
        d = cdb_dt[c*32 +: 32];
        return 1'b1;
      end
    end
    d = '0;
    return 1'b0;
  endfunction

  task automatic model_tick();
    int iss;
    int start_size;
    ment_t e;
    logic [31:0] d;
    if (rst || clr) begin
      rsq.delete();
      exp_en = 0; exp_op = '0; exp_pc = '0; exp_imm = '0; exp_rd = '0; exp_d1 = '0; exp_d2 = '0;
      return;
    end
    if (!rdy) return;
    start_size = rsq.size();
    assert (!(dp_en && start_size == DEPTH)) else begin
      errors++;
      $error("FAIL dp_into_full: observed occupancy %0d required below %0d", start_size, DEPTH);
    end
    iss = -1;
    if (ex_rdy)
      foreach (rsq[i]) if (iss < 0 && rsq[i].v1 && rsq[i].v2) iss = i;
    exp_en = (iss >= 0);
    if (iss >= 0) begin
      exp_op = rsq[iss].op; exp_pc = rsq[iss].pc; exp_imm = rsq[iss].imm;
      exp_rd = rsq[iss].rd; exp_d1 = rsq[iss].d1; exp_d2 = rsq[iss].d2;
    end
    foreach (rsq[i]) begin
      e = rsq[i];
      if (!e.v1 && cdb_hit(e.n1, d)) begin e.v1 = 1; e.d1 = d; end
      if (!e.v2 && cdb_hit(e.n2, d)) begin e.v2 = 1; e.d2 = d; end
      rsq[i] = e;
    end
    if (iss >= 0) rsq.delete(iss);
    if (dp_en && start_size < DEPTH) begin
      e.op = dp_op; e.pc = dp_pc; e.imm = dp_imm; e.rd = dp_rd;
      e.n1 = dp_n1; e.n2 = dp_n2; e.d1 = dp_d1; e.d2 = dp_d2;
      e.v1 = (dp_n1 == 0); e.v2 = (dp_n2 == 0);
      if (!e.v1 && cdb_hit(dp_n1, d)) begin e.v1 = 1; e.d1 = d; end
      if (!e.v2 && cdb_hit(dp_n2, d)) begin e.v2 = 1; e.d2 = d; end
      rsq.push_back(e);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ex_en", 64'(o_en), 64'(exp_en));
    check("ex_op", 64'(o_op), 64'(exp_op));
    check("ex_pc", 64'(o_pc), 64'(exp_pc));
    check("ex_imm", 64'(o_imm), 64'(exp_imm));
    check("ex_rd", 64'(o_rd), 64'(exp_rd));
    check("ex_rs1", 64'(o_d1), 64'(exp_d1));
    check("ex_rs2", 64'(o_d2), 64'(exp_d2));
    check("count", 64'(o_count), 64'(rsq.size()));
    check("full", 64'(o_full), 64'(rsq.size() >= DEPTH - 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  task automatic idle();
    dp_en = 0; dp_op = '0; dp_pc = '0; dp_imm = '0; dp_rd = '0;
    dp_n1 = '0; dp_n2 = '0; dp_d1 = '0; dp_d2 = '0;
    cdb_en = '0; cdb_nick = 8'h11; cdb_dt = '0; clr = 0;
  endtask

  task automatic dispatch(input logic [3:0] rd, input logic [3:0] n1, input logic [31:0] d1,
                          input logic [3:0] n2, input logic [31:0] d2);
    dp_en = 1; dp_op = 6'($urandom); dp_pc = $urandom; dp_imm = $urandom;
    dp_rd = rd; dp_n1 = n1; dp_d1 = d1; dp_n2 = n2; dp_d2 = d2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; ex_rdy = 0;
    idle();
    step(); step();
    rst = 0;
    step();
    check("t1_count", 64'(o_count), 64'd0);
    check("t1_en", 64'(o_en), 64'd0);

    // ready-at-dispatch entry issues the following cycle
    ex_rdy = 1;
    dispatch(4'd3, 4'd0, 32'd5, 4'd0, 32'd7);
    step();
    idle();
    step();
    check("t2_en", 64'(o_en), 64'd1);
    check("t2_rd", 64'(o_rd), 64'd3);
    check("t2_rs1", 64'(o_d1), 64'd5);
    check("t2_rs2", 64'(o_d2), 64'd7);
    check("t2_count", 64'(o_count), 64'd0);

    // same-cycle CDB bypass at dispatch
    dispatch(4'd5, 4'd4, 32'hdead, 4'd0, 32'd9);
    cdb_en = 2'b10; cdb_nick = {4'd4, 4'd1}; cdb_dt = {32'h55, 32'h0};
    step();
    idle();
    step();
    check("t3_en", 64'(o_en), 64'd1);
    check("t3_rs1", 64'(o_d1), 64'h55);

    // two waiters on the same tag issue oldest first
    dispatch(4'd7, 4'd6, 32'd0, 4'd0, 32'd1);
    step();
    dispatch(4'd8, 4'd6, 32'd0, 4'd0, 32'd2);
    step();
    idle();
    cdb_en = 2'b01; cdb_nick = {4'd2, 4'd6}; cdb_dt = {32'h0, 32'h66};
    step();
    idle();
    step();
    check("t4_c_rd", 64'(o_rd), 64'd7);
    check("t4_c_rs1", 64'(o_d1), 64'h66);
    step();
    check("t4_d_rd", 64'(o_rd), 64'd8);
    check("t4_d_en", 64'(o_en), 64'd1);
    step();

    // fill to DEPTH with EX stalled, then drain in dispatch order
    ex_rdy = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      dispatch(4'(i), 4'd0, 32'(i + 100), 4'd0, 32'(i + 200));
      step();
      if (i == DEPTH - 3) check("t5_full_early", 64'(o_full), 64'd0);
    end
    check("t5_full", 64'(o_full), 64'd1);
    dispatch(4'd15, 4'd0, 32'd115, 4'd0, 32'd215);
    step();
    check("t5_count_max", 64'(o_count), 64'(DEPTH));
    idle();
    ex_rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("t5_order", 64'(o_rd), 64'(i));
      check("t5_drain_en", 64'(o_en), 64'd1);
    end
    step();
    check("t5_empty", 64'(o_count), 64'd0);

    // flush with waiting entries plus concurrent dispatch and broadcast
    for (int i = 0; i < 5; i++) begin
      dispatch(4'(i + 1), 4'd9, 32'd0, 4'd0, 32'd3);
      step();
    end
    idle();
    clr = 1;
    dispatch(4'd12, 4'd0, 32'd1, 4'd0, 32'd2);
    cdb_en = 2'b01; cdb_nick = {4'd1, 4'd9}; cdb_dt = {32'h0, 32'h99};
    step();
    check("t6_count", 64'(o_count), 64'd0);
    check("t6_en", 64'(o_en), 64'd0);
    idle();
    cdb_en = 2'b01; cdb_nick = {4'd1, 4'd9}; cdb_dt = {32'h0, 32'h99};
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_issue", 64'(o_en), 64'd0);
    end

    // random traffic including rdy stalls and occasional flushes
    for (int n = 0; n < 600; n++) begin
      rdy    = ($urandom_range(0, 4) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      ex_rdy = ($urandom_range(0, 9) < 6);
      if (rsq.size() < DEPTH && $urandom_range(0, 2) != 0)
        dispatch(4'($urandom),
                 ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom,
                 ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom);
      else
        dp_en = 0;
      cdb_en   = 2'($urandom);
      cdb_nick = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
      cdb_dt   = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
